// File: rtl/pcie_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pcie_rr_arbiter
//  Brief    : Round-robin arbiter merging per-channel 512-byte read requests
//             into one request stream for the TLP generator. Outstanding
//             requests are credit-limited and retired on the final completion
//             qword of each block.
//  Revision : 1.0 - initial release
// ============================================================================
module pcie_rr_arbiter #(
    parameter int NCH     = 4,
    parameter int MAX_OUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pio_wvalid,
    input  logic [3:0]        pio_addr,
    input  logic [63:0]       pio_wdata,
    input  logic [NCH-1:0]    ch_rr_valid,
    input  logic [NCH*64-1:0] ch_rr_addr,
    output logic [NCH-1:0]    ch_rr_ready,
    output logic              req_valid,
    output logic [63:0]       req_addr,
    output logic [7:0]        req_tag,
    input  logic              req_ready,
    input  logic              rc_valid,
    input  logic [7:0]        rc_tag,
    input  logic [5:0]        rc_index,
    output logic [7:0]        outstanding
);

    localparam int              c_GW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0]      c_MAX_OUT   = 8'(MAX_OUT);
    localparam logic [5:0]      c_NCH       = 6'(NCH);
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(NCH - 1);
    localparam logic [3:0]      c_MASK_ADDR = 4'd8;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    logic [1:0]      r_state;
    logic [NCH-1:0]  r_mask;
    logic [c_GW-1:0] r_grant;
    logic [c_GW-1:0] r_last_grant;
    logic [63:0]     r_req_addr;
    logic [7:0]      r_req_tag;
    logic [7:0]      r_out;

    logic [63:0]     w_ch_addr [NCH];
    logic [NCH-1:0]  w_elig;
    logic            w_found;
    logic [c_GW-1:0] w_sel;
    logic [c_GW-1:0] w_rot;
    logic            w_credit;
    logic            w_done;
    logic            w_inc;
    logic            w_dec;
    logic            w_unused;

    // Split the flat address bus into one 64-bit word per channel
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign w_ch_addr[gi] = ch_rr_addr[64*gi +: 64];
    end

    assign w_elig   = ch_rr_valid & r_mask;
    assign w_credit = (r_out < c_MAX_OUT);

    // The last qword of a block retires one request, but only for tags that
    // map onto an existing channel; a retire at zero is a stray and dropped.
    assign w_done = rc_valid && (rc_index == 6'h3F) && ({1'b0, rc_tag[7:3]} < c_NCH);
    assign w_inc  = (r_state == c_ISSUE) && req_ready;
    assign w_dec  = w_done && (r_out != 8'd0);

    // Round-robin search: first eligible channel after the last grant
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_rot   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_rot = c_GW'((int'(r_last_grant) + k) % NCH);
            if (!w_found && w_elig[w_rot]) begin
                w_found = 1'b1;
                w_sel   = w_rot;
            end
        end
    end

    // Channel enable mask, written through the PIO register port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask <= '1;
        end else if (pio_wvalid && (pio_addr == c_MASK_ADDR)) begin
            r_mask <= pio_wdata[NCH-1:0];
        end
    end

    // Arbitration FSM; channel inputs are only looked at in IDLE because a
    // requester's valid/address are stale during its ready (GAP) cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_INIT;
            r_req_addr   <= '0;
            r_req_tag    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_credit && w_found) begin
                        r_grant    <= w_sel;
                        r_req_addr <= w_ch_addr[w_sel];
                        r_req_tag  <= {5'(w_sel), w_ch_addr[w_sel][11:9]};
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (req_ready) begin
                        r_last_grant <= r_grant;
                        r_state      <= c_GAP;
                    end
                end
                c_GAP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // In-flight counter; a simultaneous issue and retire cancel out
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out <= 8'd0;
        end else if (w_inc && !w_dec) begin
            r_out <= r_out + 8'd1;
        end else if (!w_inc && w_dec) begin
            r_out <= r_out - 8'd1;
        end
    end

    // Acceptance pulse to the granted channel during the GAP cycle
    always_comb begin
        ch_rr_ready = '0;
        if (r_state == c_GAP) begin
            ch_rr_ready[r_grant] = 1'b1;
        end
    end

    assign req_valid   = (r_state == c_ISSUE);
    assign req_addr    = r_req_addr;
    assign req_tag     = r_req_tag;
    assign outstanding = r_out;

    // Bits of the inputs that carry no meaning for this block
    assign w_unused = ^{pio_wdata, rc_tag[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_pcie_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pcie_rr_arbiter
//  Brief    : Scoreboard bench for pcie_rr_arbiter: a transaction-level model
//             queues expected grants and ready pulses, a monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_rr_arbiter;

    localparam int NCH     = 4;
    localparam int MAX_OUT = 8;

    logic              clock       = 1'b0;
    logic              reset       = 1'b1;
    logic              pio_wvalid  = 1'b0;
    logic [3:0]        pio_addr    = '0;
    logic [63:0]       pio_wdata   = '0;
    logic [NCH-1:0]    ch_rr_valid = '0;
    logic [NCH*64-1:0] ch_rr_addr  = '0;
    logic [NCH-1:0]    ch_rr_ready;
    logic              req_valid;
    logic [63:0]       req_addr;
    logic [7:0]        req_tag;
    logic              req_ready   = 1'b0;
    logic              rc_valid    = 1'b0;
    logic [7:0]        rc_tag      = '0;
    logic [5:0]        rc_index    = '0;
    logic [7:0]        outstanding;

    pcie_rr_arbiter #(.NCH(NCH), .MAX_OUT(MAX_OUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .pio_wvalid  (pio_wvalid),
        .pio_addr    (pio_addr),
        .pio_wdata   (pio_wdata),
        .ch_rr_valid (ch_rr_valid),
        .ch_rr_addr  (ch_rr_addr),
        .ch_rr_ready (ch_rr_ready),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .rc_valid    (rc_valid),
        .rc_tag      (rc_tag),
        .rc_index    (rc_index),
        .outstanding (outstanding)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   rdy_q[$];

    int             m_phase;   // 0 waiting to grant, 1 request offered, 2 ready pulse
    int             m_out;
    int             m_last;
    int             m_cur;
    int             md_c;
    logic [NCH-1:0] m_mask;
    logic           md_done, md_acc, md_dec, md_found;
    exp_t           md_e;

    initial begin : p_model
        m_phase = 0; m_out = 0; m_last = NCH - 1; m_cur = 0; m_mask = '1;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_phase = 0; m_out = 0; m_last = NCH - 1; m_mask = '1;
            end else begin
                md_done = rc_valid && (rc_index == 6'h3F) && (int'(rc_tag[7:3]) < NCH);
                md_acc  = (m_phase == 1) && req_ready;
                md_dec  = md_done && (m_out > 0);
                if (m_phase == 0) begin
                    if (m_out < MAX_OUT) begin
                        md_found = 1'b0;
                        for (int k = 1; k <= NCH; k++) begin
                            md_c = (m_last + k) % NCH;
                            if (!md_found && ch_rr_valid[md_c] && m_mask[md_c]) begin
                                md_found  = 1'b1;
                                m_cur     = md_c;
                                md_e.addr = ch_rr_addr[64*md_c +: 64];
                                md_e.tag  = 8'(md_c * 8) | 8'(md_e.addr[11:9]);
                                exp_q.push_back(md_e);
                                m_phase   = 1;
                            end
                        end
                    end
                end else if (m_phase == 1) begin
                    if (req_ready) begin
                        rdy_q.push_back(m_cur);
                        m_last  = m_cur;
                        m_phase = 2;
                    end
                end else begin
                    m_phase = 0;
                end
                m_out = m_out + (md_acc ? 1 : 0) - (md_dec ? 1 : 0);
                if (pio_wvalid && (pio_addr == 4'd8)) m_mask = pio_wdata[NCH-1:0];
            end
        end
    end

    // ---------------- monitor ----------------
    int             cyc = 0;
    int             rise_cyc = 0;
    int             seen_ch[$];
    int             seen_dly[$];
    logic           prev_rv = 1'b0;
    logic [NCH-1:0] rdy_d = '0;
    exp_t           cur;
    int             act_ch;
    int             exp_ch;

    initial begin : p_monitor
        cur.addr = '0; cur.tag = '0;
        forever begin
            @(negedge clock);
            chk("outstanding", outstanding, 64'(m_out));
            chk("req_valid", req_valid, m_phase == 1);
            if (req_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("req_addr", req_addr, cur.addr);
                    chk("req_tag", req_tag, cur.tag);
                    rise_cyc = cyc;
                end
            end else if (req_valid) begin
                chk("req_addr_stable", req_addr, cur.addr);
                chk("req_tag_stable", req_tag, cur.tag);
            end
            chk("missing_grant", exp_q.size(), 0);
            exp_q.delete();
            if (ch_rr_ready != '0) begin
                act_ch = -1;
                for (int i = NCH - 1; i >= 0; i--) if (ch_rr_ready[i]) act_ch = i;
                if (rdy_q.size() == 0) begin
                    chk("unexpected_ready", ch_rr_ready, 0);
                end else begin
                    exp_ch = rdy_q.pop_front();
                    chk("ch_rr_ready", ch_rr_ready, 64'(1) << exp_ch);
                end
                seen_ch.push_back(act_ch);
                seen_dly.push_back(cyc - rise_cyc);
            end
            chk("missing_ready", rdy_q.size(), 0);
            rdy_q.delete();
            prev_rv = req_valid;
            rdy_d   = ch_rr_ready;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    int          rmode = 0;    // 0 ready on 2nd offered cycle, 1 random, 2 one-shot
    bit          rnd = 1'b0;
    bit          refill = 1'b0;
    int          rv_age = 0;
    bit          nx_rr = 1'b0;
    bit          nx_rc = 1'b0;
    logic [7:0]  nx_tag = '0;
    logic [5:0]  nx_idx = '0;
    bit          nx_pio = 1'b0;
    logic [3:0]  nx_paddr = '0;
    logic [63:0] nx_pdata = '0;

    function automatic logic [63:0] rnd_addr();
        return {$urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (rdy_d[i]) begin
                ch_rr_valid[i] = refill;
                if (refill) ch_rr_addr[64*i +: 64] = rnd_addr();
            end
            if (rnd) begin
                if (!ch_rr_valid[i] && ($urandom % 4 == 0)) begin
                    ch_rr_valid[i] = 1'b1;
                    ch_rr_addr[64*i +: 64] = rnd_addr();
                end else if (ch_rr_valid[i] && ($urandom % 64 == 0)) begin
                    ch_rr_valid[i] = 1'b0;
                end
            end
        end
        rv_age = req_valid ? rv_age + 1 : 0;
        case (rmode)
            0:       req_ready = (rv_age >= 2);
            1:       req_ready = req_valid && ($urandom % 3 == 0);
            default: req_ready = nx_rr;
        endcase
        nx_rr = 1'b0;
        rc_valid = nx_rc; rc_tag = nx_tag; rc_index = nx_idx; nx_rc = 1'b0;
        pio_wvalid = nx_pio; pio_addr = nx_paddr; pio_wdata = nx_pdata; nx_pio = 1'b0;
        if (rnd) begin
            if ($urandom % 3 == 0) begin
                rc_valid = 1'b1;
                rc_tag   = ($urandom % 8 == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom % 32);
                rc_index = ($urandom % 4 == 0) ? 6'($urandom) : 6'h3F;
            end
            if ($urandom % 60 == 0) begin
                pio_wvalid = 1'b1;
                pio_addr   = ($urandom % 2 == 0) ? 4'd8 : 4'($urandom);
                pio_wdata  = rnd_addr();
            end
        end
    endtask

    task automatic do_reset();
        refill = 1'b0;
        ch_rr_valid = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_rv(input string nm);
        int n;
        n = 0;
        while (!req_valid && n < 40) begin
            step();
            n++;
        end
        chk(nm, req_valid, 1);
    endtask

    task automatic drain();
        refill = 1'b0;
        ch_rr_valid = '0;
        repeat (8) step();
    endtask

    task automatic all_valid();
        for (int i = 0; i < NCH; i++) ch_rr_addr[64*i +: 64] = rnd_addr();
        ch_rr_valid = '1;
    endtask

    int         ord036[5] = '{0, 1, 2, 3, 0};
    int         ord039[4] = '{0, 2, 0, 2};
    int         n;
    logic [7:0] t8;

    initial begin : p_main
        do_reset();
        chk("reset_req_valid", req_valid, 0);
        chk("reset_ch_rr_ready", ch_rr_ready, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_req_addr", req_addr, 0);
        chk("reset_req_tag", req_tag, 0);

        // Tag composition from channel number and address bits [11:9]
        rmode = 0;
        ch_rr_addr[64*2 +: 64] = 64'h0000_0000_0001_0C00;
        ch_rr_valid[2] = 1'b1;
        wait_rv("tag_grant");
        chk("tag_value", req_tag, 8'h16);
        chk("tag_addr", req_addr, 64'h0000_0000_0001_0C00);
        n = 0;
        while (outstanding != 8'd1 && n < 20) begin step(); n++; end
        chk("tag_outstanding", outstanding, 1);
        nx_rc = 1'b1; nx_tag = 8'h16; nx_idx = 6'h3F;
        step(); step();
        chk("tag_retire", outstanding, 0);
        drain();

        // Round-robin order and ready timing with all channels requesting
        do_reset();
        seen_ch.delete(); seen_dly.delete();
        refill = 1'b1;
        all_valid();
        n = 0;
        while (seen_ch.size() < 5 && n < 60) begin step(); n++; end
        chk("rr_count", seen_ch.size() >= 5, 1);
        if (seen_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rr_order%0d", i), 64'(seen_ch[i]), 64'(ord036[i]));
                chk($sformatf("rr_ready_delay%0d", i), 64'(seen_dly[i]), 2);
            end
        end
        drain();

        // Credit exhaustion and release by one completion
        do_reset();
        refill = 1'b1;
        all_valid();
        repeat (60) step();
        chk("credit_full", outstanding, MAX_OUT);
        chk("credit_stall", req_valid, 0);
        nx_rc = 1'b1; nx_tag = 8'h00; nx_idx = 6'h3F;
        step(); step();
        chk("credit_release", outstanding, MAX_OUT - 1);
        step();
        chk("credit_regrant", req_valid, 1);
        drain();

        // Simultaneous issue and retire; out-of-range tag ignored
        do_reset();
        refill = 1'b1;
        ch_rr_addr[63:0] = rnd_addr();
        ch_rr_valid[0] = 1'b1;
        n = 0;
        while (outstanding != 8'd3 && n < 40) begin step(); n++; end
        chk("sim_reach3", outstanding, 3);
        rmode = 2;
        wait_rv("sim_issue");
        refill = 1'b0;
        nx_rr = 1'b1; nx_rc = 1'b1; nx_tag = 8'h00; nx_idx = 6'h3F;
        step(); step();
        chk("sim_unchanged", outstanding, 3);
        nx_rc = 1'b1; nx_tag = 8'hF8; nx_idx = 6'h3F;
        step(); step();
        chk("bad_tag_ignored", outstanding, 3);
        rmode = 0;
        drain();

        // Enable mask 0x5: only channels 0 and 2 are served
        do_reset();
        nx_pio = 1'b1; nx_paddr = 4'd8; nx_pdata = 64'h5;
        step(); step();
        seen_ch.delete(); seen_dly.delete();
        refill = 1'b1;
        all_valid();
        n = 0;
        while (seen_ch.size() < 4 && n < 60) begin step(); n++; end
        chk("mask_count", seen_ch.size() >= 4, 1);
        if (seen_ch.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("mask_order%0d", i), 64'(seen_ch[i]), 64'(ord039[i]));
        end
        drain();

        // Reset while a request is being offered
        do_reset();
        rmode = 2;
        ch_rr_addr[64*1 +: 64] = rnd_addr();
        ch_rr_valid[1] = 1'b1;
        wait_rv("rst_issue");
        reset = 1'b1;
        ch_rr_addr[63:0] = rnd_addr();
        ch_rr_valid[0] = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_ready", ch_rr_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        step();
        chk("rst_regrant", req_valid, 1);
        t8 = req_tag;
        chk("rst_grant_ch0", t8[7:3], 0);
        rmode = 0;
        drain();

        // Randomized traffic against the model
        do_reset();
        rnd = 1'b1;
        rmode = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom % 400 == 0);
        end
        reset = 1'b0;
        rnd = 1'b0;
        rmode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_rr_arbiter.md
PCIE_RR_ARBITER -- requirements
Module: pcie_rr_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of from-PC channels sharing the read-request path (1..32).
REQ-002 SHALL have parameter MAX_OUT, default 16, meaning the maximum number of outstanding 512-byte read requests across all channels (1..255).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pio_wvalid, input, 1 bit: PIO register write strobe.
REQ-006 SHALL have port pio_addr, input, 4 bits: PIO register address.
REQ-007 SHALL have port pio_wdata, input, 64 bits: PIO write data.
REQ-008 SHALL have port ch_rr_valid, input, NCH bits: per-channel request pending.
REQ-009 SHALL have port ch_rr_addr, input, NCH*64 bits: per-channel byte address; channel i occupies bits [64i+63:64i].
REQ-010 SHALL have port ch_rr_ready, output, NCH bits: one-cycle per-channel acceptance pulse.
REQ-011 SHALL have port req_valid, output, 1 bit: merged read request to the TLP generator.
REQ-012 SHALL have port req_addr, output, 64 bits: address of the merged request.
REQ-013 SHALL have port req_tag, output, 8 bits: tag of the merged request.
REQ-014 SHALL have port req_ready, input, 1 bit: one-cycle acceptance pulse from the TLP generator.
REQ-015 SHALL have port rc_valid, input, 1 bit: read completion qword valid.
REQ-016 SHALL have port rc_tag, input, 8 bits: tag of the completion qword.
REQ-017 SHALL have port rc_index, input, 6 bits: qword index within the 512-byte block.
REQ-018 SHALL have port outstanding, output, 8 bits: current count of in-flight requests.

Function
REQ-019 SHALL hold a channel enable mask register, written when pio_wvalid is high and pio_addr==8, loading pio_wdata[NCH-1:0]; a channel whose mask bit is 0 is never granted.
REQ-020 SHALL implement a three-state FSM with states IDLE, ISSUE and GAP.
REQ-021 In IDLE, when the credit condition (outstanding < MAX_OUT) holds and any channel has both ch_rr_valid and its enable bit set, SHALL select a channel by round-robin starting at last_grant+1 (wrapping at NCH), register req_addr, req_tag and grant, and move to ISSUE.
REQ-022 req_tag SHALL be {channel number zero-extended to 5 bits, ch_rr_addr[11:9] of the granted channel}.
REQ-023 req_valid SHALL be high exactly while the FSM is in ISSUE; req_addr and req_tag SHALL stay stable throughout ISSUE.
REQ-024 In ISSUE, on req_ready==1, SHALL move to GAP, set last_grant to grant, and increment outstanding.
REQ-025 In GAP, ch_rr_ready[grant] SHALL be high for that one cycle and all other ch_rr_ready bits low; the FSM SHALL then return to IDLE unconditionally.
REQ-026 Channel inputs SHALL NOT be sampled in GAP, because a requester's valid and address are stale until the cycle after its ready pulse.
REQ-027 Minimum grant-to-grant spacing SHALL be 3 cycles (IDLE, ISSUE, GAP); the latency from IDLE with an eligible request to req_valid SHALL be 1 cycle.
REQ-028 A completion-done event SHALL be rc_valid==1 with rc_index==6'h3F and rc_tag[7:3] < NCH; it SHALL decrement outstanding by 1.
REQ-029 When an increment (REQ-024) and a completion-done event occur in the same cycle, outstanding SHALL be unchanged.
REQ-030 A completion-done event while outstanding==0 SHALL be ignored; outstanding SHALL never wrap below 0.
REQ-031 outstanding SHALL never exceed MAX_OUT.
REQ-032 A channel deasserting ch_rr_valid, or being disabled, while it is in ISSUE SHALL NOT abort the request; the latched request completes normally.
REQ-033 Completions with rc_tag[7:3] >= NCH SHALL have no effect.

Reset
REQ-034 On reset SHALL set: FSM to IDLE, req_valid=0, ch_rr_ready=0, outstanding=0, enable mask all ones, last_grant=NCH-1 (so that channel 0 is preferred first), req_addr=0, req_tag=0.
REQ-035 Reset asserted mid-ISSUE or mid-GAP SHALL drop the request without any ch_rr_ready pulse; reset has priority over all other updates.

Verification
REQ-036 All 4 channels valid, req_ready pulsed 1 cycle after each req_valid -> grant order 0,1,2,3,0; each ch_rr_ready pulse is exactly 1 cycle, 2 cycles after its req_valid rose.
REQ-037 MAX_OUT=2, no completions -> after 2 grants req_valid stays 0 and outstanding==2; one rc_valid with rc_index=63 and rc_tag=0x00 -> outstanding==1 and a grant issues in the next IDLE cycle.
REQ-038 Channel 2 with ch_rr_addr=0x0000_0000_0001_0C00 -> req_tag==0x16 and req_addr==0x0000_0000_0001_0C00.
REQ-039 PIO write addr 8 data 0x5 with all channels valid -> only channels 0 and 2 are granted, alternating.
REQ-040 req_ready and a completion-done event in the same cycle with outstanding==3 -> outstanding remains 3; a completion with rc_tag=0xF8 -> no change.
REQ-041 Reset asserted during ISSUE -> next cycle req_valid=0, no ch_rr_ready pulse, outstanding=0, and the next grant goes to channel 0.
